// File: rtl/infer_pkg.sv
// Shared types and constants for the inference sequencer and its address counters.
package infer_pkg;

    localparam int ROWS  = 8;
    localparam int ROW_W = 64;
    localparam int CNT_W = 7;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_W,
        LOAD_W,
        WAIT_W,
        STREAM,
        DRAIN,
        FINISH
    } infer_state_t;

endpackage

// File: rtl/row_addr_counter.sv
// Loadable base address plus row count; the address wraps modulo 2^ADDR_W and tc
// flags that the count has reached the limit (further increments are ignored).
module row_addr_counter
    import infer_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] base,
    input  logic              inc,
    input  logic [CNT_W-1:0]  limit,
    output logic [ADDR_W-1:0] addr,
    output logic              tc
);

    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        base_d = base_q;
        cnt_d  = cnt_q;
        if (load) begin
            base_d = base;
            cnt_d  = '0;
        end else if (inc && !tc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            base_q <= '0;
            cnt_q  <= '0;
        end else begin
            base_q <= base_d;
            cnt_q  <= cnt_d;
        end
    end

    assign tc   = (cnt_q == limit);
    assign addr = base_q + ADDR_W'(cnt_q);

endmodule

// File: rtl/inference_driver.sv
// Host-side sequencer for the systolic array: weight load, input stream, activation write-back.
// Define INFER_TIMEOUT_EN to compile in the WAIT_W/DRAIN stall watchdog that drives err.
//
// state   | meaning
// IDLE    | waiting for start
// FETCH_W | weight row 0 read issued
// LOAD_W  | weight rows presented to the array, next read in flight
// WAIT_W  | waiting for systolic_done from the array
// STREAM  | input rows presented with enable high
// DRAIN   | pipeline flushing, activations still being captured
// FINISH  | one-cycle done pulse
module inference_driver
    import infer_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int ROWS    = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_inputs,
    input  logic [ADDR_W-1:0] w_base,
    input  logic [ADDR_W-1:0] in_base,
    input  logic [ADDR_W-1:0] out_base,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [ROW_W-1:0]  rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ROW_W-1:0]  wr_data,
    output logic              start_weights,
    output logic              start_array,
    output logic              enable,
    output logic [ROW_W-1:0]  systolic_data,
    input  logic [ROW_W-1:0]  activations,
    input  logic              activated,
    input  logic              systolic_done
);

    infer_state_t      state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              sw_q, sw_d;
    logic              sa_q, sa_d;
    logic              en_q, en_d;
    logic              sel_q, sel_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ROW_W-1:0]  wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] in_base_q, in_base_d;
    logic [CNT_W-1:0]  n_q, n_d;

    logic              rd_issue, rd_load, rd_tc;
    logic              wr_load, wr_tc, capture, wd_fire;
    logic [ADDR_W-1:0] rd_base, rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  rd_limit;

    // The read counter serves the weight fetch first, then is reloaded for the input stream.
    assign rd_base  = (state_q == IDLE) ? w_base : in_base_q;
    assign rd_limit = (state_q == FETCH_W || state_q == LOAD_W) ? CNT_W'(ROWS) : n_q;
    assign capture  = activated && (state_q == STREAM || state_q == DRAIN) && !wr_tc;

    row_addr_counter #(.ADDR_W(ADDR_W)) u_rd_cnt (
        .clk   (clk),
        .n_rst (n_rst),
        .load  (rd_load),
        .base  (rd_base),
        .inc   (rd_issue),
        .limit (rd_limit),
        .addr  (rd_ptr),
        .tc    (rd_tc)
    );

    row_addr_counter #(.ADDR_W(ADDR_W)) u_wr_cnt (
        .clk   (clk),
        .n_rst (n_rst),
        .load  (wr_load),
        .base  (out_base),
        .inc   (capture),
        .limit (n_q),
        .addr  (wr_ptr),
        .tc    (wr_tc)
    );

`ifdef INFER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            waiting, progress;

    always_comb begin
        waiting  = (state_q == WAIT_W) || (state_q == DRAIN);
        progress = systolic_done || activated;
        wd_d     = '0;
        if (waiting && !progress) begin
            wd_d = wd_q + 1'b1;
        end
        wd_fire = waiting && !progress && (wd_q == WD_W'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign wd_fire = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        sw_d      = 1'b0;
        sa_d      = 1'b0;
        en_d      = en_q;
        wr_en_d   = capture;
        wr_addr_d = capture ? wr_ptr : '0;
        wr_data_d = capture ? activations : '0;
        in_base_d = in_base_q;
        n_d       = n_q;
        rd_issue  = 1'b0;
        rd_load   = 1'b0;
        wr_load   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    n_d   = num_inputs;
                    if (num_inputs == '0) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = FETCH_W;
                        busy_d    = 1'b1;
                        rd_load   = 1'b1;
                        wr_load   = 1'b1;
                        in_base_d = in_base;
                    end
                end
            end
            FETCH_W: begin
                rd_issue = 1'b1;
                sw_d     = 1'b1;
                state_d  = LOAD_W;
            end
            LOAD_W: begin
                rd_issue = !rd_tc;
                if (rd_tc) begin
                    rd_load = 1'b1;
                    state_d = WAIT_W;
                end
            end
            WAIT_W: begin
                if (systolic_done) begin
                    rd_issue = 1'b1;
                    sa_d     = 1'b1;
                    en_d     = 1'b1;
                    state_d  = STREAM;
                end else if (wd_fire) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    en_d    = 1'b0;
                    err_d   = 1'b1;
                end
            end
            STREAM: begin
                rd_issue = !rd_tc;
                if (rd_tc) begin
                    if (wr_tc) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        en_d    = 1'b0;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (wr_tc) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    en_d    = 1'b0;
                end else if (wd_fire) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    en_d    = 1'b0;
                    err_d   = 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // sel marks cycles whose rd_data answers a read issued by this pass.
    assign sel_d = rd_issue;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            sw_q      <= 1'b0;
            sa_q      <= 1'b0;
            en_q      <= 1'b0;
            sel_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            in_base_q <= '0;
            n_q       <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            sw_q      <= sw_d;
            sa_q      <= sa_d;
            en_q      <= en_d;
            sel_q     <= sel_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            in_base_q <= in_base_d;
            n_q       <= n_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign rd_en         = rd_issue;
    assign rd_addr       = rd_issue ? rd_ptr : '0;
    assign wr_en         = wr_en_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign start_weights = sw_q;
    assign start_array   = sa_q;
    assign enable        = en_q;
    assign systolic_data = sel_q ? rd_data : '0;

endmodule

// File: tb/tb_inference_driver.sv
// Directed bench for inference_driver with a dual-port SRAM model and a systolic-array stub.
module tb_inference_driver;

    localparam logic [63:0] ACT_MASK = 64'hFFFF_0000_FFFF_0000;

    logic        clk;
    logic        n_rst;
    logic        start;
    logic [6:0]  num_inputs;
    logic [7:0]  w_base, in_base, out_base;
    logic        busy, done, err;
    logic        rd_en, wr_en;
    logic [7:0]  rd_addr, wr_addr;
    logic [63:0] rd_data, wr_data;
    logic        start_weights, start_array, enable;
    logic [63:0] systolic_data, activations;
    logic        activated, systolic_done;

    int err_cnt = 0;
    int chk_cnt = 0;

    logic [63:0] mem [0:255];
    logic [7:0]  rd_log [0:63];
    logic [7:0]  wa_log [0:63];
    logic [63:0] wd_log [0:63];
    int          rd_n, wr_n, done_n, sw_n;
    logic [63:0] sw_data;

    int          stub_n;
    bit          sd_on;
    int          sd_t, rows_left;
    logic        s1_v, s2_v;
    logic [63:0] s1_d, s2_d;

    inference_driver dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .start         (start),
        .num_inputs    (num_inputs),
        .w_base        (w_base),
        .in_base       (in_base),
        .out_base      (out_base),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .start_weights (start_weights),
        .start_array   (start_array),
        .enable        (enable),
        .systolic_data (systolic_data),
        .activations   (activations),
        .activated     (activated),
        .systolic_done (systolic_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    // Array stub: systolic_done 10 cycles after start_weights, activation 2 cycles after each row.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sd_t          <= 0;
            systolic_done <= 1'b0;
            rows_left     <= 0;
            s1_v          <= 1'b0;
            s2_v          <= 1'b0;
            s1_d          <= '0;
            s2_d          <= '0;
        end else begin
            systolic_done <= 1'b0;
            if (start_weights) sd_t <= 1;
            else if (sd_t == 9) begin
                sd_t          <= 0;
                systolic_done <= sd_on;
            end else if (sd_t > 0) sd_t <= sd_t + 1;
            s1_v <= start_array || (rows_left > 0);
            s1_d <= systolic_data;
            if (start_array) rows_left <= stub_n - 1;
            else if (rows_left > 0) rows_left <= rows_left - 1;
            s2_v <= s1_v;
            s2_d <= s1_d;
        end
    end
    assign activated   = s2_v;
    assign activations = s2_d ^ ACT_MASK;

    always @(negedge clk) begin
        if (rd_en && rd_n < 64) begin
            rd_log[rd_n] = rd_addr;
            rd_n++;
        end
        if (wr_en && wr_n < 64) begin
            wa_log[wr_n] = wr_addr;
            wd_log[wr_n] = wr_data;
            wr_n++;
        end
        if (done) done_n++;
        if (start_weights) begin
            sw_n++;
            sw_data = systolic_data;
        end
    end

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk_eq({tag, "_busy"}, 64'(busy), 64'd0);
        chk_eq({tag, "_done"}, 64'(done), 64'd0);
        chk_eq({tag, "_err"}, 64'(err), 64'd0);
        chk_eq({tag, "_rd_en"}, 64'(rd_en), 64'd0);
        chk_eq({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
        chk_eq({tag, "_wr_en"}, 64'(wr_en), 64'd0);
        chk_eq({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
        chk_eq({tag, "_wr_data"}, wr_data, 64'd0);
        chk_eq({tag, "_start_weights"}, 64'(start_weights), 64'd0);
        chk_eq({tag, "_start_array"}, 64'(start_array), 64'd0);
        chk_eq({tag, "_enable"}, 64'(enable), 64'd0);
        chk_eq({tag, "_systolic_data"}, systolic_data, 64'd0);
    endtask

    task automatic run_pass(input string name, input logic [7:0] wb, input logic [7:0] ib,
                            input logic [7:0] ob, input int n, input bit dup, input bit sd,
                            input int exp_cyc, input bit exp_err);
        int         cyc;
        bit         got_done;
        int         exp_wr, exp_rd;
        logic [7:0] a;
        @(negedge clk);
        rd_n = 0; wr_n = 0; done_n = 0; sw_n = 0; sw_data = '0;
        w_base = wb; in_base = ib; out_base = ob;
        num_inputs = 7'(n); stub_n = n; sd_on = sd;
        start = 1'b1;
        cyc = 0; got_done = 1'b0;
        while (!got_done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            start = (dup && start_array) ? 1'b1 : 1'b0;
            if (cyc == 1 && n > 0) chk_eq({name, "_busy_after_start"}, 64'(busy), 64'd1);
            if (done) got_done = 1'b1;
        end
        start = 1'b0;
        chk_eq({name, "_done_cycle"}, 64'(cyc), 64'(exp_cyc));
        chk_eq({name, "_err"}, 64'(err), 64'(exp_err));
        chk_eq({name, "_busy_at_done"}, 64'(busy), 64'd0);
        repeat (60) @(negedge clk);
        exp_wr = exp_err ? 0 : n;
        exp_rd = (n == 0) ? 0 : (exp_err ? 8 : 8 + n);
        chk_eq({name, "_done_pulses"}, 64'(done_n), 64'd1);
        chk_eq({name, "_write_count"}, 64'(wr_n), 64'(exp_wr));
        chk_eq({name, "_read_count"}, 64'(rd_n), 64'(exp_rd));
        chk_eq({name, "_sw_pulses"}, 64'(sw_n), (n > 0) ? 64'd1 : 64'd0);
        if (n > 0) chk_eq({name, "_sw_row0"}, sw_data, mem[wb]);
        for (int k = 0; k < 8 && k < exp_rd; k++) begin
            a = wb + 8'(k);
            chk_eq($sformatf("%s_wrd_addr%0d", name, k), 64'(rd_log[k]), 64'(a));
        end
        for (int k = 0; k < exp_rd - 8; k++) begin
            a = ib + 8'(k);
            chk_eq($sformatf("%s_ird_addr%0d", name, k), 64'(rd_log[8 + k]), 64'(a));
        end
        for (int k = 0; k < exp_wr && k < 64; k++) begin
            a = ob + 8'(k);
            chk_eq($sformatf("%s_wr_addr%0d", name, k), 64'(wa_log[k]), 64'(a));
            a = ib + 8'(k);
            chk_eq($sformatf("%s_wr_data%0d", name, k), wd_log[k], mem[a] ^ ACT_MASK);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int cyc;
        for (int i = 0; i < 256; i++) mem[i] = 64'(i) * 64'h9E37_79B9_7F4A_7C15 + 64'd1;
        n_rst = 1'b0; start = 1'b0; num_inputs = '0;
        w_base = '0; in_base = '0; out_base = '0;
        stub_n = 0; sd_on = 1'b1;
        rd_n = 0; wr_n = 0; done_n = 0; sw_n = 0; sw_data = '0;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        // done latency = 16 + n with systolic_done 10 cycles after start_weights
        run_pass("basic", 8'h00, 8'h10, 8'h20, 8, 1'b0, 1'b1, 24, 1'b0);
        run_pass("zero", 8'h00, 8'h10, 8'h20, 0, 1'b0, 1'b1, 1, 1'b0);
        run_pass("wrap", 8'h40, 8'hFE, 8'h80, 4, 1'b0, 1'b1, 20, 1'b0);
        run_pass("busy_start", 8'h00, 8'h10, 8'h50, 4, 1'b1, 1'b1, 20, 1'b0);

        @(negedge clk);
        w_base = 8'h00; in_base = 8'h10; out_base = 8'h20;
        num_inputs = 7'd8; stub_n = 8; sd_on = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!start_array && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk_eq("rst_reach_stream", 64'(start_array), 64'd1);
        repeat (8) @(negedge clk);
        chk_eq("rst_pre_enable", 64'(enable), 64'd1);
        #1 n_rst = 1'b0;
        #1 chk_outputs_zero("mid_reset");
        @(negedge clk);
        chk_eq("mid_reset_no_done", 64'(done), 64'd0);
        n_rst = 1'b1;
        run_pass("after_reset", 8'h00, 8'h10, 8'h20, 8, 1'b0, 1'b1, 24, 1'b0);

`ifdef INFER_TIMEOUT_EN
        run_pass("watchdog", 8'h00, 8'h10, 8'h30, 4, 1'b0, 1'b0, 74, 1'b1);
        run_pass("err_clear", 8'h00, 8'h10, 8'h30, 4, 1'b0, 1'b1, 20, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/inference_driver.md
Name: inference_driver

Overview:
- Host-side sequencer that drives the fullInference datapath and collects its results.
- Runs one full pass per start pulse:
  - fetches 8 weight rows from a row-wide SRAM and streams them in;
  - streams num_inputs input rows with the array enable held high;
  - drains the pipeline and writes each activation vector back to SRAM.
- Sits between the top-level host/SRAM and fullInference, on the opposite side of the start_weights/start_array/enable/systolic_data/activated/systolic_done interface.

Parameters:
- ADDR_W, 8, SRAM word-address width.
- ROWS, 8, weight rows per load; equals array dimension.
- TIMEOUT, 64, watchdog limit in cycles; used only with INFER_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a pass; ignored while busy.
- num_inputs  in  7  input rows per pass, 0..127; sampled on the accepted start.
- w_base  in  ADDR_W  SRAM address of weight row 0; sampled on start.
- in_base  in  ADDR_W  SRAM address of input row 0; sampled on start.
- out_base  in  ADDR_W  SRAM address for activation row 0; sampled on start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at pass completion.
- err  out  1  watchdog fired; valid with done.
- rd_en  out  1  SRAM read strobe.
- rd_addr  out  ADDR_W  SRAM read address.
- rd_data  in  64  read data, valid exactly 1 cycle after rd_en.
- wr_en  out  1  SRAM write strobe.
- wr_addr  out  ADDR_W  SRAM write address.
- wr_data  out  64  SRAM write data.
- start_weights  out  1  weight-load pulse to the array.
- start_array  out  1  input-stream pulse to the array.
- enable  out  1  array advance enable.
- systolic_data  out  64  row presented to the array.
- activations  in  64  activation vector from the array.
- activated  in  1  activations valid this cycle.
- systolic_done  in  1  weight load complete.

Behaviour:
- Reset values: every output 0; state IDLE; all counters 0. Reset mid-pass aborts immediately with no done pulse.
- FSM states: IDLE, FETCH_W, LOAD_W, WAIT_W, STREAM, DRAIN, FINISH.
- IDLE:
  - start with num_inputs==0 -> FINISH; done pulses the next cycle; no SRAM traffic.
  - start otherwise -> latch num_inputs and base addresses; go to FETCH_W; busy=1.
- FETCH_W: rd_en=1, rd_addr=w_base; go to LOAD_W.
- LOAD_W:
  - Each cycle, systolic_data = rd_data from the previous read.
  - start_weights=1 only on the cycle row 0 is presented.
  - Reads w_base+1..w_base+ROWS-1 are issued back-to-back, so rows 0..7 appear on 8 consecutive cycles.
  - enable=0 throughout.
  - After row 7 -> WAIT_W, with systolic_data=0.
- WAIT_W:
  - Hold until systolic_done is high.
  - In that same cycle: rd_en=1, rd_addr=in_base; go to STREAM.
- STREAM:
  - enable=1; systolic_data = input row k on cycle k.
  - start_array=1 on the cycle row 0 is presented.
  - Reads are pipelined one ahead, addresses wrap modulo 2^ADDR_W.
  - After num_inputs rows -> DRAIN.
- DRAIN: enable=1, systolic_data=0, until all activations are captured.
- Capture (STREAM and DRAIN):
  - When activated=1: wr_en=1, wr_addr=out_base+cap_cnt, wr_data=activations; then cap_cnt++.
  - When cap_cnt reaches num_inputs -> FINISH.
  - activated outside STREAM/DRAIN is ignored.
- FINISH: done=1 for one cycle, busy=0, enable=0 -> IDLE.
- Read and write strobes may coincide in one cycle; the SRAM is dual-port.
- start while busy: ignored, no side effects.

Optional Feature:
- INFER_TIMEOUT_EN defined:
  - A watchdog counts cycles spent in WAIT_W or DRAIN without progress (no systolic_done, no activated).
  - On reaching TIMEOUT -> FINISH with err=1 alongside done.
  - err clears on the next accepted start.
- INFER_TIMEOUT_EN undefined: no watchdog, err tied 0, and WAIT_W/DRAIN wait indefinitely.

Decomposition:
- Package infer_pkg:
  - state enum infer_state_t;
  - localparams ROWS=8, ROW_W=64, CNT_W=7.
- One sub-module, row_addr_counter:
  - loadable base + count with wrap-around and a terminal-count flag;
  - instantiated once for the read side and once for the write side.

Test Plan:
- Basic pass:
  - Stimulus: weights at 0x00-0x07, inputs at 0x10-0x17, num_inputs=8, out_base=0x20; stub array asserts systolic_done 10 cycles after start_weights and activated 2 cycles after each streamed row.
  - Response: start_weights on the cycle with row 0x00 data; 8 writes to 0x20-0x27 with matching data; one done pulse; err=0.
- Zero inputs: start with num_inputs=0 -> done one cycle later; rd_en and wr_en never assert.
- Address wrap: in_base=0xFE, num_inputs=4 -> reads issued to 0xFE, 0xFF, 0x00, 0x01.
- Start while busy: second start pulse mid-STREAM -> ignored; only one done; exactly num_inputs writes.
- Reset mid-pass: n_rst low during DRAIN -> all outputs 0 on the same cycle; next start runs a full clean pass.
- Watchdog (INFER_TIMEOUT_EN, TIMEOUT=64): systolic_done never asserted -> done with err=1 exactly 64 cycles after entering WAIT_W.
